fir_xifu_sboard: RTL and testbench
==================================

FIR_XIFU_SBOARD -- requirements
Module: fir_xifu_sboard

Interface
REQ-001 The module SHALL have parameter NUM_ID, default 16, meaning the number of tracked XIF instruction IDs (power of two, 2..64).
REQ-002 The module SHALL have parameter MAX_OUTST, default NUM_ID, meaning the maximum number of simultaneously non-free IDs (1..NUM_ID).
REQ-003 The module SHALL have parameter DEDUP, default 1, meaning a repeated commit to an already committed/killed ID is silently dropped (0: flagged as error).
REQ-004 clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 issue_valid_i  in  1  accepted-issue strobe; issue_id_i  in  ID_W  issued ID; issue_ready_o  out  1  slot available.
REQ-006 commit_valid_i  in  1  commit strobe; commit_id_i  in  ID_W  committed ID; commit_kill_i  in  1  kill qualifier.
REQ-007 clear_i  in  NUM_ID  per-ID retire strobe from WB.
REQ-008 issued_o, committed_o, killed_o  out  NUM_ID each  registered per-ID state flags.
REQ-009 ex_commit_o  out  NUM_ID  combinational committed-and-not-killed view for EX.
REQ-010 outst_o  out  ID_W+1  registered count of non-free IDs; err_o  out  1  sticky protocol error.

Function
REQ-011 Each ID SHALL hold a 2-bit state: FREE, ISSUED, COMMITTED, KILLED.
REQ-012 FREE->ISSUED when issue_valid_i and issue_id_i==ID and issue_ready_o.
REQ-013 ISSUED->COMMITTED on commit to ID with kill=0; ISSUED->KILLED on commit with kill=1.
REQ-014 Issue and commit to the same FREE ID in the same cycle SHALL move it directly to COMMITTED or KILLED.
REQ-015 COMMITTED or KILLED->FREE when clear_i[ID]=1; clear SHALL have priority over issue and commit for that ID in the same cycle.
REQ-016 Issue to a non-FREE ID (state_q) SHALL be ignored and set err_o.
REQ-017 Commit to a FREE ID without same-cycle issue SHALL be ignored and set err_o.
REQ-018 Commit to a COMMITTED/KILLED ID SHALL be ignored; err_o set only when DEDUP=0.
REQ-019 Clear to FREE or ISSUED ID SHALL be ignored and set err_o.
REQ-020 issue_valid_i while issue_ready_o=0 SHALL be ignored, no error.
REQ-021 issued_o[i]=(state_q!=FREE), committed_o[i]=(state_q==COMMITTED), killed_o[i]=(state_q==KILLED); one cycle latency from event.
REQ-022 ex_commit_o[i] SHALL equal (state_d==COMMITTED), i.e. zero-latency on the commit cycle.
REQ-023 outst_o SHALL equal popcount of non-FREE state_q; multiple clears per cycle SHALL decrement correctly.
REQ-024 issue_ready_o SHALL be (outst_o < MAX_OUTST), registered-derived, never combinational from inputs.
REQ-025 err_o SHALL remain 1 until reset once set.

Reset
REQ-026 On rst_ni=0 all IDs SHALL become FREE, outst_o=0, err_o=0, issue_ready_o=1, all flag vectors 0, immediately and asynchronously.
REQ-027 Reset mid-operation SHALL discard all pending IDs; no clear is required afterwards.

Structure
REQ-028 State enum, ID_W=$clog2(NUM_ID) derivation and struct bundling flag vectors SHALL live in fir_xifu_pkg.
REQ-029 One sub-module fir_xifu_sboard_entry (per-ID FSM) SHALL be instantiated NUM_ID times via generate; counter and error logic stay in top.

Verification
REQ-030 Issue id 3, commit id 3 kill=0 next cycle -> ex_commit_o[3]=1 same cycle, committed_o[3]=1 next cycle; clear_i[3] -> outst_o back to 0.
REQ-031 Issue id 5 and commit id 5 kill=1 same cycle -> killed_o[5]=1 next cycle, ex_commit_o[5]=0, err_o=0.
REQ-032 MAX_OUTST=4: issue ids 0..3 -> issue_ready_o=0, issue id 4 ignored, outst_o=4; clear ids 0 and 2 same cycle -> outst_o=2, issue_ready_o=1.
REQ-033 DEDUP=1: commit id 7 three consecutive cycles after issue -> single transition, err_o=0; DEDUP=0 same stimulus -> err_o=1.
REQ-034 Commit id 9 never issued -> state unchanged, err_o=1 sticky; clear_i[2] with commit id 2 same cycle on COMMITTED id 2 -> FREE.
REQ-035 Assert rst_ni with 6 IDs outstanding -> all flags 0, outst_o=0, issue_ready_o=1 without clock edge.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// Purpose: shared types and helpers for the XIF instruction-ID scoreboard.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fir_xifu_pkg;

    // Lifecycle of one tracked XIF instruction ID.
    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ISSUED    = 2'd1,
        ST_COMMITTED = 2'd2,
        ST_KILLED    = 2'd3
    } id_state_e;

    // Registered per-ID flags. The top fans these out into its flag vectors.
    typedef struct packed {
        logic issued;
        logic committed;
        logic killed;
    } id_flags_t;

    // Per-ID protocol violations seen in the current cycle.
    typedef struct packed {
        logic issue_busy;   // issue to a non-FREE ID
        logic commit_free;  // commit to a FREE ID with no accepted same-cycle issue
        logic commit_dup;   // repeated commit, reported only when dedup is disabled
        logic clear_early;  // clear to a FREE or ISSUED ID
    } id_err_t;

    localparam int unsigned NUM_ID_DEF = 16;

    // ID field width for a given number of tracked IDs.
    function automatic int unsigned calc_id_w(input int unsigned num_id);
        return (num_id > 1) ? $clog2(num_id) : 1;
    endfunction

endpackage

// File: rtl/fir_xifu_sboard_entry.sv
// Purpose: lifecycle FSM for one instruction ID (FREE/ISSUED/COMMITTED/KILLED).
// Latency: flags 1 cycle after the event; ex_commit_o and busy_d_o same cycle.
// Backpressure: none; the caller qualifies issue_i with its ready.
// Ports: clk_i/rst_ni; issue_i, commit_i, kill_i, clear_i already decoded for
//        this ID; flags_o registered flags; ex_commit_o and busy_d_o are
//        next-state views; err_o reports violations this cycle.
module fir_xifu_sboard_entry
    import fir_xifu_pkg::*;
#(
    parameter bit DEDUP = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      issue_i,
    input  logic      commit_i,
    input  logic      kill_i,
    input  logic      clear_i,
    output id_flags_t flags_o,
    output logic      ex_commit_o,
    output logic      busy_d_o,
    output id_err_t   err_o
);

    id_state_e state_q, state_d;
    logic      retired_q;

    assign retired_q = (state_q == ST_COMMITTED) || (state_q == ST_KILLED);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. A valid clear wins over anything else aimed at this ID.
    // An invalid clear is only an error, so issue/commit still take effect.
    always_comb begin
        state_d = state_q;
        if (clear_i && retired_q) begin
            state_d = ST_FREE;
        end else begin
            case (state_q)
                ST_FREE: begin
                    // Issue and commit in the same cycle skip ISSUED.
                    if (issue_i) begin
                        if (commit_i) begin
                            state_d = kill_i ? ST_KILLED : ST_COMMITTED;
                        end else begin
                            state_d = ST_ISSUED;
                        end
                    end
                end
                ST_ISSUED: begin
                    if (commit_i) begin
                        state_d = kill_i ? ST_KILLED : ST_COMMITTED;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        flags_o.issued    = (state_q != ST_FREE);
        flags_o.committed = (state_q == ST_COMMITTED);
        flags_o.killed    = (state_q == ST_KILLED);
        ex_commit_o       = (state_d == ST_COMMITTED);
        busy_d_o          = (state_d != ST_FREE);

        err_o.issue_busy  = issue_i && (state_q != ST_FREE);
        err_o.commit_free = commit_i && !issue_i && (state_q == ST_FREE);
        err_o.commit_dup  = commit_i && retired_q && !DEDUP;
        err_o.clear_early = clear_i && !retired_q;
    end

endmodule

// File: rtl/fir_xifu_sboard.sv
// Purpose: scoreboard tracking the issue/commit/retire lifecycle of XIF IDs.
// Latency: state flags and outst_o 1 cycle after the event; ex_commit_o 0 cycles.
// Backpressure: issue_ready_o drops when MAX_OUTST IDs are non-free; an issue
//               offered while it is low is dropped without error.
// Ports: issue_valid_i/issue_id_i/issue_ready_o accepted issues;
//        commit_valid_i/commit_id_i/commit_kill_i commits; clear_i per-ID retire;
//        issued_o/committed_o/killed_o registered flags; ex_commit_o
//        next-state committed view; outst_o non-free count; err_o sticky error.
module fir_xifu_sboard
    import fir_xifu_pkg::*;
#(
    parameter  int unsigned NUM_ID    = NUM_ID_DEF,
    parameter  int unsigned MAX_OUTST = NUM_ID,
    parameter  bit          DEDUP     = 1'b1,
    localparam int unsigned ID_W      = calc_id_w(NUM_ID)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_valid_i,
    input  logic [ID_W-1:0]   issue_id_i,
    output logic              issue_ready_o,
    input  logic              commit_valid_i,
    input  logic [ID_W-1:0]   commit_id_i,
    input  logic              commit_kill_i,
    input  logic [NUM_ID-1:0] clear_i,
    output logic [NUM_ID-1:0] issued_o,
    output logic [NUM_ID-1:0] committed_o,
    output logic [NUM_ID-1:0] killed_o,
    output logic [NUM_ID-1:0] ex_commit_o,
    output logic [ID_W:0]     outst_o,
    output logic              err_o
);

    localparam logic [ID_W:0] MAX_OUTST_C = (ID_W + 1)'(MAX_OUTST);

    logic [ID_W:0]     outst_q, outst_d;
    logic              err_q;
    logic              issue_acc;
    logic [NUM_ID-1:0] busy_d;
    logic [NUM_ID-1:0] err_any;
    id_flags_t         flags [NUM_ID];
    id_err_t           errs  [NUM_ID];

    // Ready comes only from the registered count, so an issue cannot
    // combinationally gate itself.
    assign issue_ready_o = (outst_q < MAX_OUTST_C);
    assign issue_acc     = issue_valid_i && issue_ready_o;

    for (genvar i = 0; i < NUM_ID; i++) begin : g_entry
        localparam logic [ID_W-1:0] MY_ID = ID_W'(i);

        fir_xifu_sboard_entry #(
            .DEDUP (DEDUP)
        ) u_entry (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .issue_i     (issue_acc && (issue_id_i == MY_ID)),
            .commit_i    (commit_valid_i && (commit_id_i == MY_ID)),
            .kill_i      (commit_kill_i),
            .clear_i     (clear_i[i]),
            .flags_o     (flags[i]),
            .ex_commit_o (ex_commit_o[i]),
            .busy_d_o    (busy_d[i]),
            .err_o       (errs[i])
        );

        assign issued_o[i]    = flags[i].issued;
        assign committed_o[i] = flags[i].committed;
        assign killed_o[i]    = flags[i].killed;
        assign err_any[i]     = |errs[i];
    end

    // Recount from next state every cycle. This handles several clears plus
    // an issue in one cycle without tracking increments/decrements.
    always_comb begin
        outst_d = '0;
        for (int unsigned k = 0; k < NUM_ID; k++) begin
            outst_d = outst_d + {{ID_W{1'b0}}, busy_d[k]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            err_q   <= err_q || (|err_any);
        end
    end

    assign outst_o = outst_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_fir_xifu_sboard.sv
module tb_fir_xifu_sboard;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        iv, cv, ck;
    logic [3:0]  iid, cid;
    logic [15:0] clr;

    // Default instance, MAX_OUTST=4 instance, DEDUP=0 instance; shared stimulus.
    logic        a_rdy, b_rdy, c_rdy;
    logic [15:0] a_iss, a_com, a_kil, a_exc;
    logic [15:0] b_iss, b_com, b_kil, b_exc;
    logic [15:0] c_iss, c_com, c_kil, c_exc;
    logic [4:0]  a_out, b_out, c_out;
    logic        a_err, b_err, c_err;

    always #5 clk = ~clk;

    fir_xifu_sboard u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(iv), .issue_id_i(iid), .issue_ready_o(a_rdy),
        .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
        .clear_i(clr), .issued_o(a_iss), .committed_o(a_com), .killed_o(a_kil),
        .ex_commit_o(a_exc), .outst_o(a_out), .err_o(a_err)
    );

    fir_xifu_sboard #(.MAX_OUTST(4)) u_dut_max4 (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(iv), .issue_id_i(iid), .issue_ready_o(b_rdy),
        .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
        .clear_i(clr), .issued_o(b_iss), .committed_o(b_com), .killed_o(b_kil),
        .ex_commit_o(b_exc), .outst_o(b_out), .err_o(b_err)
    );

    fir_xifu_sboard #(.DEDUP(1'b0)) u_dut_nodedup (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(iv), .issue_id_i(iid), .issue_ready_o(c_rdy),
        .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
        .clear_i(clr), .issued_o(c_iss), .committed_o(c_com), .killed_o(c_kil),
        .ex_commit_o(c_exc), .outst_o(c_out), .err_o(c_err)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    task automatic push(input string tag, input logic [63:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL sb_underflow: observed %0h with no expected entry queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    // Advance one clock; inputs return to idle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        iv = 1'b0; cv = 1'b0; ck = 1'b0; clr = '0;
    endtask

    task automatic reset_pulse();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        iv = 1'b0; cv = 1'b0; ck = 1'b0; iid = '0; cid = '0; clr = '0;

        // Reset state
        push("rst_outst", 0); push("rst_ready", 1); push("rst_err", 0);
        push("rst_issued", 0);
        #1;
        chk(a_out); chk(a_rdy); chk(a_err); chk(a_iss);
        step();
        rst_ni = 1'b1;

        // Issue 3, commit 3 next cycle, clear 3
        iv = 1'b1; iid = 4'd3;
        push("a_issued3", 1); push("a_outst1", 1);
        step();
        chk(a_iss[3]); chk(a_out);
        cv = 1'b1; cid = 4'd3; ck = 1'b0;
        push("a_excommit3_same", 1); push("a_committed3_before", 0);
        #1;
        chk(a_exc[3]); chk(a_com[3]);
        push("a_committed3", 1);
        step();
        chk(a_com[3]);
        clr = 16'h0008;
        push("a_clear_outst0", 0); push("a_clear_issued", 0); push("a_clear_err", 0);
        step();
        chk(a_out); chk(a_iss); chk(a_err);

        // Issue and kill id 5 in the same cycle
        iv = 1'b1; iid = 4'd5; cv = 1'b1; cid = 4'd5; ck = 1'b1;
        push("b_excommit5", 0);
        #1;
        chk(a_exc[5]);
        push("b_killed5", 1); push("b_committed5", 0); push("b_err", 0); push("b_outst1", 1);
        step();
        chk(a_kil[5]); chk(a_com[5]); chk(a_err); chk(a_out);
        clr = 16'h0020;
        step();

        // Triple commit of id 7: dedup vs error
        iv = 1'b1; iid = 4'd7;
        step();
        for (int n = 0; n < 3; n++) begin
            cv = 1'b1; cid = 4'd7; ck = 1'b0;
            step();
        end
        push("c_committed7", 1); push("c_err_dedup", 0); push("c_err_nodedup", 1);
        push("c_outst1", 1);
        chk(a_com[7]); chk(a_err); chk(c_err); chk(a_out);
        clr = 16'h0080;
        step();

        // MAX_OUTST=4 occupancy limit
        for (int n = 0; n < 4; n++) begin
            iv = 1'b1; iid = 4'(n);
            step();
        end
        push("d_ready0", 0); push("d_outst4", 4);
        chk(b_rdy); chk(b_out);
        iv = 1'b1; iid = 4'd4;
        push("d_id4_ignored", 0); push("d_outst_still4", 4); push("d_err_noerr", 0);
        step();
        chk(b_iss[4]); chk(b_out); chk(b_err);
        cv = 1'b1; cid = 4'd0; step();
        cv = 1'b1; cid = 4'd2; step();
        clr = 16'h0005;
        push("d_outst2", 2); push("d_ready1", 1); push("d_main_outst3", 3);
        step();
        chk(b_out); chk(b_rdy); chk(a_out);

        // Asynchronous reset with 6 IDs outstanding
        for (int n = 0; n < 3; n++) begin
            iv = 1'b1; iid = (n == 2) ? 4'd5 : 4'(2 * n);
            step();
        end
        push("e_outst6", 6);
        chk(a_out);
        rst_ni = 1'b0;
        push("e_rst_outst", 0); push("e_rst_issued", 0); push("e_rst_committed", 0);
        push("e_rst_killed", 0); push("e_rst_ready", 1); push("e_rst_err_nodedup", 0);
        #1;
        chk(a_out); chk(a_iss); chk(a_com); chk(a_kil); chk(a_rdy); chk(c_err);
        step();
        rst_ni = 1'b1;

        // Commit to never-issued id 9; clear and commit together on id 2
        cv = 1'b1; cid = 4'd9;
        push("f_issued9", 0); push("f_committed9", 0); push("f_err", 1);
        step();
        chk(a_iss[9]); chk(a_com[9]); chk(a_err);
        push("f_err_sticky", 1);
        step();
        chk(a_err);
        iv = 1'b1; iid = 4'd2; step();
        cv = 1'b1; cid = 4'd2;
        push("f_committed2", 1);
        step();
        chk(a_com[2]);
        clr = 16'h0004; cv = 1'b1; cid = 4'd2;
        push("f_clear2_free", 0); push("f_outst0", 0);
        step();
        chk(a_iss[2]); chk(a_out);

        // Clear to a FREE id
        reset_pulse();
        clr = 16'h0002;
        push("g_clear_free_err", 1); push("g_clear_free_issued", 0);
        step();
        chk(a_err); chk(a_iss);

        // Issue to a non-FREE id
        reset_pulse();
        iv = 1'b1; iid = 4'd6; step();
        iv = 1'b1; iid = 4'd6;
        push("h_reissue_err", 1); push("h_outst1", 1);
        step();
        chk(a_err); chk(a_out);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL sb_drain: observed %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
